// File: rtl/img_stream_pkg.sv
// img_stream_pkg: shared types, defaults and helpers for the raster pixel stream
package img_stream_pkg;
  localparam int DEF_IMG_WIDTH = 422;
  localparam int DEF_IMG_HEIGHT = 413;
  typedef logic [7:0] pixel_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} stream_state_t;
  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry register FIFO with occupancy count; caller never pops when empty
module stream_fifo2 import img_stream_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  pixel_t     din,
  input  logic       pop,
  output pixel_t     head,
  output logic [1:0] count
);
  pixel_t mem [2];
  logic rp, wp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rp <= 1'b0;
      wp <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  assign head = mem[rp];
  // the read-issue rule upstream keeps a push from ever landing on a full FIFO
  always_ff @(posedge clk)
    if (!rst) assert (!(push && count == 2'd2)) else $error("stream_fifo2 overflow");
endmodule

// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: streams a WxH 8-bit frame from a sync-read RAM in raster order
module pixel_frame_streamer import img_stream_pkg::*; #(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        pixel_data,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              stream_active,
  output logic              sof,
  output logic              eol,
  output logic              frame_done,
  output logic              busy
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [ADDR_W:0] N = (ADDR_W+1)'(frame_pixels(IMG_WIDTH, IMG_HEIGHT));
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  stream_state_t state, state_nx;
  logic [ADDR_W:0] rd_addr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0] count;
  logic [2:0] occ;
  logic inflight, pop, last_pop, act_r;
  stream_fifo2 u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .din(mem_rd_data),
    .pop(pop),
    .head(pixel_data),
    .count(count)
  );
  assign pixel_valid = count != 2'd0;
  assign pop = pixel_valid && pixel_ready;
  assign last_pop = pop && row == ROW_MAX && col == COL_MAX;
  // occupancy one cycle ahead: buffered minus leaving plus the read already in flight
  assign occ = 3'(count) + 3'(inflight) - 3'(pop);
  assign mem_rd_en = state == FETCH && rd_addr < N && occ < 3'd2;
  assign mem_rd_addr = rd_addr[ADDR_W-1:0];
  assign sof = pixel_valid && row == '0 && col == '0;
  assign eol = pixel_valid && col == COL_MAX;
  assign frame_done = state == DONE;
  assign busy = state != IDLE;
  assign stream_active = pixel_valid || act_r;
  always_comb begin
    state_nx = state == IDLE  ? (frame_start ? FETCH : IDLE) :
               state == FETCH ? (rd_addr == N ? DRAIN : FETCH) :
               state == DRAIN ? (last_pop ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_addr <= '0;
      inflight <= 1'b0;
      col <= '0;
      row <= '0;
      act_r <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= mem_rd_en;
      act_r <= last_pop ? 1'b0 : act_r | pixel_valid;
      if (state == IDLE && frame_start) rd_addr <= '0;
      else if (mem_rd_en) rd_addr <= rd_addr + (ADDR_W+1)'(1);
      if (pop) begin
        col <= col == COL_MAX ? '0 : col + CW'(1);
        row <= col != COL_MAX ? row : row == ROW_MAX ? '0 : row + RW'(1);
      end
    end
endmodule
